hazard_scoreboard: RTL

- Next-generation hazard controller for the 5-stage RISC-V pipeline. It sits between decode and execute.
- Keeps a per-register scoreboard for long-latency writers (multi-cycle mul/div, variable-latency loads) and an outstanding-operation counter.
- Also detects single-cycle load-use hazards and raises flushes on branch/jump redirect.
- Produces the PC/IF-ID stall, IF-ID/ID-EX flush and issue-qualify signals.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_scoreboard_if.sv | 48 ++++
 rtl/sb_regfile_bits.sv | 38 +++
 rtl/hazard_scoreboard.sv | 113 +++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller.
// Holds the default register-file geometry, the x0 index constant and the
// encoding of the three-way output priority (redirect > hazard > issue).
package hazard_pkg;

  localparam int NREGS_DEF    = 32;
  localparam int REG_AW_DEF   = 5;
  localparam int MAX_PEND_DEF = 4;
  localparam int CNT_W_DEF    = 3;

  // Architectural x0: never busy, never matches a hazard comparison.
  localparam int X0_IDX = 0;

  typedef enum logic [1:0] {
    PRI_ISSUE    = 2'd0,
    PRI_HAZARD   = 2'd1,
    PRI_REDIRECT = 2'd2
  } pri_e;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute/writeback bundle for the hazard controller.
// slave  : the controller (takes ID/EX/WB info, drives stall/flush/issue,
//          exposes scoreboard state).
// master : the pipeline side (drives ID/EX/WB info, observes controls).
interface hazard_scoreboard_if #(
  parameter int NREGS  = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 3
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic              id_rs1_used;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_long;
  logic              ex_valid;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_redirect;
  logic              wb_long_valid;
  logic [REG_AW-1:0] wb_long_rd;
  logic              pc_stall;
  logic              if_id_stall;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              id_issue;
  logic [CNT_W-1:0]  pending_cnt;
  logic [NREGS-1:0]  sb_busy;
  logic              err_spurious;

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
           id_rd_we, id_is_long, ex_valid, ex_rd, ex_mem_read, ex_redirect,
           wb_long_valid, wb_long_rd,
    output pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_issue,
           pending_cnt, sb_busy, err_spurious
  );

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used, id_rd,
           id_rd_we, id_is_long, ex_valid, ex_rd, ex_mem_read, ex_redirect,
           wb_long_valid, wb_long_rd,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_flush, id_issue,
           pending_cnt, sb_busy, err_spurious
  );
endinterface

// File: rtl/sb_regfile_bits.sv
// Per-register busy vector for long-latency writers.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   set_en, set_idx    mark register busy next cycle
//   clr_en, clr_idx    mark register free next cycle
//   busy               registered busy vector, bit 0 forced 0
// When set and clear hit the same register, set wins.
module sb_regfile_bits
  import hazard_pkg::*;
#(
  parameter int NREGS  = NREGS_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_idx,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_idx,
  output logic [NREGS-1:0]  busy
);

  logic [NREGS-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_idx] = 1'b0;
    // Applied after the clear so a colliding set survives.
    if (set_en) busy_nxt[set_idx] = 1'b1;
    busy_nxt[X0_IDX] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller between decode and execute of the 5-stage pipeline.
// Ports:
//   clk, rst  clock, synchronous active-high reset (overrides all events)
//   bus       hazard_scoreboard_if.slave: ID/EX/WB inputs; pc_stall,
//             if_id_stall, if_id_flush, id_ex_flush, id_issue (combinational),
//             pending_cnt, sb_busy, err_spurious (registered)
// Detects scoreboard RAW/WAW, single-cycle load-use and outstanding-capacity
// hazards, and gives an EX redirect priority over any stall.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREGS    = NREGS_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  hazard_scoreboard_if.slave  bus
);

  logic [NREGS-1:0] busy;
  logic [CNT_W-1:0] cnt;
  logic             err;

  logic rs1_nz, rs2_nz, rd_nz, ex_rd_nz, wb_rd_nz;
  logic raw, waw, lu, cap, hazard;
  logic set, clr, spurious;
  pri_e pri;

  // Index 0 never matches; busy[0] is already 0, the explicit terms keep
  // load-use from matching an x0 source.
  assign rs1_nz   = bus.id_rs1     != REG_AW'(X0_IDX);
  assign rs2_nz   = bus.id_rs2     != REG_AW'(X0_IDX);
  assign rd_nz    = bus.id_rd      != REG_AW'(X0_IDX);
  assign ex_rd_nz = bus.ex_rd      != REG_AW'(X0_IDX);
  assign wb_rd_nz = bus.wb_long_rd != REG_AW'(X0_IDX);

  assign raw = (bus.id_rs1_used & rs1_nz & busy[bus.id_rs1]) |
               (bus.id_rs2_used & rs2_nz & busy[bus.id_rs2]);
  assign waw = bus.id_rd_we & rd_nz & busy[bus.id_rd];
  assign lu  = bus.ex_valid & bus.ex_mem_read & ex_rd_nz &
               ((bus.id_rs1_used & (bus.ex_rd == bus.id_rs1)) |
                (bus.id_rs2_used & (bus.ex_rd == bus.id_rs2)));
  // A writeback in this same cycle does not relieve capacity.
  assign cap    = bus.id_is_long & (cnt == CNT_W'(MAX_PEND));
  assign hazard = bus.id_valid & (raw | waw | lu | cap);

  always_comb begin
    if (bus.ex_redirect) pri = PRI_REDIRECT;
    else if (hazard)     pri = PRI_HAZARD;
    else                 pri = PRI_ISSUE;
  end

  always_comb begin
    bus.pc_stall    = 1'b0;
    bus.if_id_stall = 1'b0;
    bus.if_id_flush = 1'b0;
    bus.id_ex_flush = 1'b0;
    bus.id_issue    = 1'b0;
    case (pri)
      PRI_REDIRECT: begin
        bus.if_id_flush = 1'b1;
        bus.id_ex_flush = 1'b1;
      end
      PRI_HAZARD: begin
        bus.pc_stall    = 1'b1;
        bus.if_id_stall = 1'b1;
        bus.id_ex_flush = 1'b1;
      end
      default: bus.id_issue = bus.id_valid;
    endcase
  end

  // Long ops to x0 or without rd_we occupy no bit and are not counted.
  assign set      = bus.id_issue & bus.id_is_long & bus.id_rd_we & rd_nz;
  assign clr      = bus.wb_long_valid & wb_rd_nz & busy[bus.wb_long_rd];
  assign spurious = bus.wb_long_valid & ~clr;

  sb_regfile_bits #(
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_bits (
    .clk     (clk),
    .rst     (rst),
    .set_en  (set),
    .set_idx (bus.id_rd),
    .clr_en  (clr),
    .clr_idx (bus.wb_long_rd),
    .busy    (busy)
  );

  // Set+clear together (different or forced-same register) leaves the
  // count unchanged; saturating guards keep it within 0..MAX_PEND.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case ({set, clr})
        2'b10:   if (cnt != CNT_W'(MAX_PEND)) cnt <= cnt + CNT_W'(1);
        2'b01:   if (cnt != '0)               cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
      if (spurious) err <= 1'b1;
    end
  end

  assign bus.sb_busy      = busy;
  assign bus.pending_cnt  = cnt;
  assign bus.err_spurious = err;

endmodule
